// File: rtl/dot_update_sequencer_if.sv
// Bundle of the processor-side write/commit signals and the VGA dot-update outputs.
// master: processor/VGA side driving the inputs; slave: dot_update_sequencer.
interface dot_update_sequencer_if;
    logic        wr_en;
    logic        wr_is_y;
    logic [31:0] wr_id;
    logic [31:0] wr_data;
    logic        commit;
    logic        frame_end;
    logic        dotWren;
    logic        is_Yloc;
    logic [31:0] dotID;
    logic [31:0] dotLoc;
    logic        busy;
    logic        done;

    modport master (
        output wr_en, wr_is_y, wr_id, wr_data, commit, frame_end,
        input  dotWren, is_Yloc, dotID, dotLoc, busy, done
    );

    modport slave (
        input  wr_en, wr_is_y, wr_id, wr_data, commit, frame_end,
        output dotWren, is_Yloc, dotID, dotLoc, busy, done
    );
endinterface

// File: rtl/dot_update_sequencer.sv
// Shadow dot-coordinate table published to the VGA controller once per commit, on a frame edge.
// Optional macro DOT_CLAMP_EN: clamp written coordinates to X_MAX/Y_MAX instead of truncating.
module dot_update_sequencer #(
    parameter int unsigned NUM_DOTS    = 8,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned X_INIT      = 320,
    parameter int unsigned Y_INIT      = 240,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MAX       = 479
) (
    input logic                   clk,
    input logic                   reset,
    dot_update_sequencer_if.slave io_bus
);

    localparam int unsigned DOT_W  = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int unsigned IDX_W  = DOT_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(2 * NUM_DOTS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [9:0]        X_INIT_L  = 10'(X_INIT);
    localparam logic [8:0]        Y_INIT_L  = 9'(Y_INIT);

    typedef enum logic [1:0] {StIdle, StArmed, StSend} state_e;

    state_e             r_state;
    logic               r_pending;
    logic               r_fe;
    logic [IDX_W-1:0]   r_idx;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_dot_wren;
    logic               r_is_yloc;
    logic [31:0]        r_dot_id;
    logic [31:0]        r_dot_loc;
    logic               r_busy;
    logic               r_done;

    logic [9:0] r_shadow_x [NUM_DOTS];
    logic [8:0] r_shadow_y [NUM_DOTS];
    logic [9:0] r_send_x   [NUM_DOTS];
    logic [8:0] r_send_y   [NUM_DOTS];

    logic             w_fe_edge;
    logic             w_load;
    logic             w_wr_hit;
    logic [DOT_W-1:0] w_wr_dot;
    logic [9:0]       w_wr_x;
    logic [8:0]       w_wr_y;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [DOT_W-1:0] w_nxt_dot;
    logic             w_nxt_is_y;
    logic [31:0]      w_nxt_loc;

    // r_fe resets high so a frame_end already asserted at reset release is not an edge
    assign w_fe_edge = io_bus.frame_end & ~r_fe;
    assign w_load    = (r_state == StArmed) && w_fe_edge;
    assign w_wr_hit  = io_bus.wr_en && (io_bus.wr_id < NUM_DOTS);
    assign w_wr_dot  = io_bus.wr_id[DOT_W-1:0];

`ifdef DOT_CLAMP_EN
    assign w_wr_x = (io_bus.wr_data > X_MAX) ? 10'(X_MAX) : io_bus.wr_data[9:0];
    assign w_wr_y = (io_bus.wr_data > Y_MAX) ? 9'(Y_MAX) : io_bus.wr_data[8:0];
`else
    logic w_unused_data;
    assign w_wr_x        = io_bus.wr_data[9:0];
    assign w_wr_y        = io_bus.wr_data[8:0];
    assign w_unused_data = ^io_bus.wr_data[31:10];
`endif

    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_nxt_dot  = w_idx_nxt[IDX_W-1:1];
    assign w_nxt_is_y = w_idx_nxt[0];
    assign w_nxt_loc  = w_nxt_is_y ? 32'(r_send_y[w_nxt_dot]) : 32'(r_send_x[w_nxt_dot]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_DOTS); i++) begin
                r_shadow_x[i] <= X_INIT_L;
                r_shadow_y[i] <= Y_INIT_L;
            end
        end else if (w_wr_hit) begin
            if (io_bus.wr_is_y) begin
                r_shadow_y[w_wr_dot] <= w_wr_y;
            end else begin
                r_shadow_x[w_wr_dot] <= w_wr_x;
            end
        end
    end

    // Snapshot taken on the frame edge; later shadow writes only affect the next publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_DOTS); i++) begin
                r_send_x[i] <= X_INIT_L;
                r_send_y[i] <= Y_INIT_L;
            end
        end else if (w_load) begin
            r_send_x <= r_shadow_x;
            r_send_y <= r_shadow_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_pending  <= 1'b0;
            r_fe       <= 1'b1;
            r_idx      <= '0;
            r_hold     <= '0;
            r_dot_wren <= 1'b0;
            r_is_yloc  <= 1'b0;
            r_dot_id   <= '0;
            r_dot_loc  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_fe   <= io_bus.frame_end;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.commit) begin
                        r_state <= StArmed;
                        r_busy  <= 1'b1;
                    end
                end
                StArmed: begin
                    if (w_fe_edge) begin
                        r_state    <= StSend;
                        r_idx      <= '0;
                        r_hold     <= '0;
                        r_dot_wren <= 1'b1;
                        r_is_yloc  <= 1'b0;
                        r_dot_id   <= '0;
                        r_dot_loc  <= 32'(r_shadow_x[0]);
                    end
                end
                StSend: begin
                    if (io_bus.commit) begin
                        r_pending <= 1'b1;
                    end
                    if (r_hold == HOLD_LAST) begin
                        r_hold <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_dot_wren <= 1'b0;
                            r_is_yloc  <= 1'b0;
                            r_dot_id   <= '0;
                            r_dot_loc  <= '0;
                            r_done     <= 1'b1;
                            r_pending  <= 1'b0;
                            if (r_pending || io_bus.commit) begin
                                r_state <= StArmed;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_is_yloc <= w_nxt_is_y;
                            r_dot_id  <= 32'(w_nxt_dot);
                            r_dot_loc <= w_nxt_loc;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.dotWren = r_dot_wren;
    assign io_bus.is_Yloc = r_is_yloc;
    assign io_bus.dotID   = r_dot_id;
    assign io_bus.dotLoc  = r_dot_loc;
    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;

endmodule

// File: tb/tb_dot_update_sequencer.sv
// Scoreboard bench for dot_update_sequencer: frames are queued when the frame edge is driven,
// a negedge monitor pops and checks every held write and the end-of-frame behaviour.
module tb_dot_update_sequencer;

    localparam int HOLD  = 4;
    localparam int NDOTS = 8;
    localparam int NWR   = 2 * NDOTS;

    typedef struct {
        int id;
        int isy;
        int loc;
    } wr_t;

    typedef struct {
        bit busy;
        bit aborted;
    } end_t;

    logic clk;
    logic reset;

    dot_update_sequencer_if bus ();

    dot_update_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   exp_dones = 0;
    int   run = 0;
    wr_t  exp_q [$];
    end_t end_q [$];
    wr_t  cur;
    int   model_x [NDOTS];
    int   model_y [NDOTS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per HOLD-cycle write, then an end-of-frame record
    always @(negedge clk) begin
        if (bus.dotWren === 1'b1) begin
            if (run % HOLD == 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                    cur = '{id: -1, isy: 0, loc: 0};
                end else begin
                    cur = exp_q.pop_front();
                    check("dot_id", bus.dotID, cur.id);
                    check("is_yloc", {31'd0, bus.is_Yloc}, cur.isy);
                    check("dot_loc", bus.dotLoc, cur.loc);
                end
            end else begin
                check("hold_loc", bus.dotLoc, cur.loc);
                check("hold_id", bus.dotID, cur.id);
            end
            check("busy_in_send", {31'd0, bus.busy}, 32'd1);
            run++;
        end else if (run != 0) begin
            if (end_q.size() == 0) begin
                check("unexpected_frame_end", 32'd1, 32'd0);
            end else begin
                end_t e;
                e = end_q.pop_front();
                if (!e.aborted) begin
                    check("frame_length", run, NWR * HOLD);
                    check("done_at_end", {31'd0, bus.done}, 32'd1);
                    check("busy_after_frame", {31'd0, bus.busy}, {31'd0, e.busy});
                end else begin
                    check("no_done_on_abort", {31'd0, bus.done}, 32'd0);
                    for (int i = (run + HOLD - 1) / HOLD; i < NWR; i++) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end
                end
            end
            run = 0;
        end
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDOTS; i++) begin
            model_x[i] = 320;
            model_y[i] = 240;
        end
    endtask

    // exp is the hand-computed stored coordinate for this write
    task automatic wr(input logic [31:0] id, input bit is_y, input logic [31:0] data, input int exp);
        bus.wr_en   = 1'b1;
        bus.wr_is_y = is_y;
        bus.wr_id   = id;
        bus.wr_data = data;
        step(1);
        bus.wr_en = 1'b0;
        if (id < NDOTS) begin
            if (is_y) model_y[id] = exp;
            else      model_x[id] = exp;
        end
    endtask

    task automatic commit_pulse();
        bus.commit = 1'b1;
        step(1);
        bus.commit = 1'b0;
        check("busy_after_commit", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic frame(input bit busy_after, input bit aborted);
        for (int k = 0; k < NWR; k++) begin
            exp_q.push_back('{id: k >> 1, isy: k & 1, loc: (k & 1) ? model_y[k >> 1] : model_x[k >> 1]});
        end
        end_q.push_back('{busy: busy_after, aborted: aborted});
        if (!aborted) exp_dones++;
        bus.frame_end = 1'b1;
        step(1);
        check("wren_first_cycle", {31'd0, bus.dotWren}, 32'd1);
        check("first_loc", bus.dotLoc, model_x[0]);
        step(1);
        bus.frame_end = 1'b0;
    endtask

    task automatic wait_done(input bit busy_exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
        check("busy_at_done", {31'd0, bus.busy}, {31'd0, busy_exp});
        step(1);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_is_y   = 1'b0;
        bus.wr_id     = '0;
        bus.wr_data   = '0;
        bus.commit    = 1'b0;
        bus.frame_end = 1'b0;
        reset         = 1'b1;
        model_reset();
        #1;
        check("rst_wren", {31'd0, bus.dotWren}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_id", bus.dotID, 32'd0);
        check("rst_loc", bus.dotLoc, 32'd0);
        step(2);
        reset = 1'b0;
        step(8);

        // Defaults only
        commit_pulse();
        step(2);
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        // dot3 = (100, 50)
        wr(3, 1'b0, 100, 100);
        wr(3, 1'b1, 50, 50);
        commit_pulse();
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        // Clamp vs truncate on dot2
`ifdef DOT_CLAMP_EN
        wr(2, 1'b0, 700, 639);
        wr(2, 1'b1, 600, 479);
`else
        wr(2, 1'b0, 700, 700);
        wr(2, 1'b1, 600, 88);
`endif
        commit_pulse();
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        // Write + commit together mid-SEND: current frame unchanged, pending re-arms
        commit_pulse();
        frame(1'b1, 1'b0);
        step(8);
        bus.wr_en   = 1'b1;
        bus.wr_is_y = 1'b0;
        bus.wr_id   = 0;
        bus.wr_data = 5;
        bus.commit  = 1'b1;
        step(1);
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
        model_x[0] = 5;
        wait_done(1'b1);
        check("still_armed", {31'd0, bus.busy}, 32'd1);
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        // frame_end high through reset release gives no edge
        bus.frame_end = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        model_reset();
        step(5);
        check("fe_high_no_busy", {31'd0, bus.busy}, 32'd0);
        wr(8, 1'b0, 1, 1);
        wr(32'h0000_0100, 1'b1, 3, 3);
        commit_pulse();
        step(5);
        check("fe_high_no_send", {31'd0, bus.dotWren}, 32'd0);
        bus.frame_end = 1'b0;
        step(2);
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        // Reset at SEND cycle 20
        wr(1, 1'b0, 77, 77);
        commit_pulse();
        frame(1'b0, 1'b1);
        step(18);
        #2;
        reset = 1'b1;
        #1;
        check("abort_wren", {31'd0, bus.dotWren}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        step(2);
        reset = 1'b0;
        model_reset();
        step(2);
        commit_pulse();
        frame(1'b0, 1'b0);
        wait_done(1'b0);

        step(4);
        check("done_count", done_seen, exp_dones);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_update_sequencer.md
# dot_update_sequencer

Processor-side writer for the VGA dot-position port. Holds a shadow table of per-dot X/Y coordinates written by the processor. On a commit request it waits for the next frame boundary, then streams every coordinate to the VGA controller as a sequence of `dotWren`/`is_Yloc`/`dotID`/`dotLoc` writes. Each write is held long enough for the 25 MHz pixel-clock domain to sample it. It sits between the processor's memory-mapped I/O decode and the VGA controller's dot update inputs.

## Interface
- `NUM_DOTS`, 8, number of dots in the table.
- `HOLD_CYCLES`, 4, clk cycles each write is held; must be ≥ 4 so that at least one clk25 rising edge falls inside every write.
- `X_INIT`, 320, reset X of every dot.
- `Y_INIT`, 240, reset Y of every dot.
- `X_MAX`, 639, X clamp limit.
- `Y_MAX`, 479, Y clamp limit.

Ports:
- `clk` in 1: 100 MHz system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: shadow-table write strobe, one write per cycle.
- `wr_is_y` in 1: 1 writes Y, 0 writes X.
- `wr_id` in 32: dot index; a value ≥ NUM_DOTS makes the write ignored.
- `wr_data` in 32: coordinate (unsigned).
- `commit` in 1: single-cycle request to publish the table.
- `frame_end` in 1: VGA `screenEnd`; only its rising edge is used.
- `dotWren` out 1: write valid to the VGA controller.
- `is_Yloc` out 1: 1 means `dotLoc` is a Y coordinate.
- `dotID` out 32: dot index, zero-extended.
- `dotLoc` out 32: coordinate, zero-extended.
- `busy` out 1: high in ARMED or SEND.
- `done` out 1: single-cycle pulse when a publish completes.

## Operation
- Shadow table: NUM_DOTS × (10-bit X, 9-bit Y). The table is writable in every state, and writes take effect the next cycle.
- Send buffer: a separate copy of the shadow table. It is loaded in a single cycle on ARMED→SEND. Shadow writes made during SEND do not alter the frame currently being sent.
- Frame-edge detection: a `frame_end` edge is `frame_end & ~fe_q`, where `fe_q` is a register that resets to 1. A `frame_end` that is already high out of reset therefore produces no edge.
- States:
  - IDLE: `busy`=0. A `commit` moves to ARMED.
  - ARMED: waits for a `frame_end` edge, then loads the send buffer, clears the write index and hold counter, and moves to SEND.
  - SEND: drives the write at index k, where `dotID` = k>>1 and `is_Yloc` = k[0]. The order is dot0 X, dot0 Y, dot1 X, … up to the last dot's Y. Each index is held HOLD_CYCLES cycles. After the final index, go to IDLE and pulse `done`.
- `dotWren` stays high continuously for the whole SEND. Only `dotID`, `is_Yloc` and `dotLoc` change at index boundaries.
- A `commit` received in ARMED is absorbed, with no effect.
- A `commit` received in SEND sets `pending`. On SEND exit, if `pending` is set, go to ARMED instead of IDLE and clear `pending`; `done` still pulses.
- A simultaneous `wr_en` and `commit` is valid: the write is included in the publish, because the send buffer is loaded no earlier than the next cycle.

## Timing
- Reset values: all outputs are 0, state is IDLE, `pending` is 0, and all shadow and send entries are X_INIT/Y_INIT.
- If `commit` is seen in cycle t while IDLE, `busy` is 1 from t+1.
- If a `frame_end` edge is seen in cycle t while ARMED, then from t+1:
  - `dotWren` is 1 with dot 0 X.
  - Index k is driven in cycles t+1+k·HOLD_CYCLES through t+(k+1)·HOLD_CYCLES.
- With N = 2·NUM_DOTS·HOLD_CYCLES:
  - In cycle t+1+N: `dotWren`=0, `done`=1, and `busy`=0 (or 1 if `pending` was set).
  - For the defaults, N = 64.
- A `frame_end` edge outside ARMED is ignored.
- If reset is asserted mid-SEND, outputs clear immediately (asynchronously) and no `done` is produced.

## Configuration
- `DOT_CLAMP_EN` defined: on shadow write, X = min(`wr_data`, X_MAX) and Y = min(`wr_data`, Y_MAX), comparing the full 32-bit value.
- `DOT_CLAMP_EN` undefined: X = `wr_data[9:0]` and Y = `wr_data[8:0]`, truncated without a compare.

## Test plan
- Reset only, then commit at cycle 10, then a `frame_end` pulse → 16 writes of 4 cycles each, with X=320/Y=240 for IDs 0–7, followed by a one-cycle `done`.
- Write dot3 X=100 and Y=50, commit, then `frame_end` → the writes at k=6 and k=7 carry 100 and 50; all other dots carry 320/240.
- Write dot2 X=700 → `dotLoc`=639 with `DOT_CLAMP_EN`, and 700 mod 1024 = 700 without it. Write Y=600 → 479 with the macro, and 600 mod 512 = 88 without it.
- Shadow write dot0 X=5 at SEND cycle 10, with `commit` in the same cycle → the current frame still sends 320. `busy` stays 1, the next frame edge re-sends with 5, and two `done` pulses occur.
- `wr_id`=8 with X=1 → the table is unchanged. `frame_end` held high through reset release → no SEND until commit plus a fresh rising edge.
- Reset asserted at SEND cycle 20 → `dotWren`, `busy` and `done` are 0 at once, and the table is back at 320/240.
